systolic_sequencer: RTL and testbench

Controller that sequences one matrix multiply through the `dim_p` x `dim_p` systolic array. It collects operand matrices A and B from a serial ready/valid stream, then drives them into the array's west and north edges with diagonal skew. It waits for the array to drain and returns the `dim_p*dim_p` accumulator results on a serial valid/yumi stream. It sits between the `top` serial interface and the PE grid.

---
 rtl/systolic_sequencer_if.sv | 31 +++
 rtl/systolic_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_systolic_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_sequencer_if.sv
// systolic_sequencer_if: operand ready/valid stream and result valid/yumi stream.
// slave is the sequencer side, master is the producer/consumer side.
interface systolic_sequencer_if #(
  parameter int width_p     = 8,
  parameter int acc_width_p = 16
);
  logic                   valid_i;
  logic                   ready_o;
  logic [width_p-1:0]     data_i;
  logic                   valid_o;
  logic                   yumi_i;
  logic [acc_width_p-1:0] data_o;

  modport slave (
    input  valid_i,
    output ready_o,
    input  data_i,
    output valid_o,
    input  yumi_i,
    output data_o
  );

  modport master (
    output valid_i,
    input  ready_o,
    output data_i,
    input  valid_o,
    output yumi_i,
    input  data_o
  );
endinterface

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: loads A/B, skews them into a dim_p x dim_p array, unloads results.
// Define SYSTOLIC_SEQ_PERF_CNT_EN to add the perf_cycles_o cycle counter.
module systolic_sequencer #(
  parameter int width_p     = 8,
  parameter int dim_p       = 2,
  parameter int acc_width_p = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic                               en_i,
  input  logic                               flush_i,
  systolic_sequencer_if.slave                io,
  output logic [dim_p*width_p-1:0]           row_data_o,
  output logic [dim_p-1:0]                   row_valid_o,
  output logic [dim_p*width_p-1:0]           col_data_o,
  output logic [dim_p-1:0]                   col_valid_o,
  output logic                               arr_clear_o,
  input  logic [dim_p*dim_p*acc_width_p-1:0] arr_result_i,
  output logic                               busy_o
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                        perf_cycles_o
`endif
);

  localparam int n_lp     = dim_p * dim_p;
  localparam int cnt_w_lp = $clog2(2 * n_lp);

  typedef logic [cnt_w_lp-1:0] cnt_t;

  typedef enum logic [2:0] {
    LOAD,
    CLEAR,
    FEED,
    DRAIN,
    UNLOAD
  } state_e;

  state_e state_q, state_n;
  cnt_t   cnt_q, cnt_n;

  logic [width_p-1:0] a_q [n_lp];
  logic [width_p-1:0] b_q [n_lp];

  logic [dim_p*width_p-1:0] row_d, col_d;
  logic [dim_p-1:0]         row_v, col_v;
  logic [dim_p*width_p-1:0] row_data_q, col_data_q;
  logic [dim_p-1:0]         row_valid_q, col_valid_q;
  logic                     clear_q;
  logic                     valid_q;
  logic [acc_width_p-1:0]   data_q;
  logic [acc_width_p-1:0]   res_sel;

  logic ready, beat, yumi;

  assign ready = en_i & (state_q == LOAD);
  assign beat  = ready & io.valid_i;
  assign yumi  = en_i & valid_q & io.yumi_i;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      LOAD: begin
        if (beat) begin
          if (cnt_q == cnt_t'(2 * n_lp - 1)) begin
            state_n = CLEAR;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        state_n = FEED;
        cnt_n   = '0;
      end
      FEED: begin
        if (cnt_q == cnt_t'(2 * dim_p - 2)) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == cnt_t'(dim_p - 1)) begin
          state_n = UNLOAD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      UNLOAD: begin
        if (yumi) begin
          if (cnt_q == cnt_t'(n_lp - 1)) begin
            state_n = LOAD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_n = LOAD;
        cnt_n   = '0;
      end
    endcase
  end

  // Row r and column r share the skew window: element j enters at t = r + j.
  always_comb begin
    row_d = '0;
    row_v = '0;
    col_d = '0;
    col_v = '0;
    if (state_q == FEED) begin
      for (int r = 0; r < dim_p; r++) begin
        for (int j = 0; j < dim_p; j++) begin
          if (cnt_q == cnt_t'(r + j)) begin
            row_d[r*width_p +: width_p] = a_q[r*dim_p+j];
            row_v[r]                    = 1'b1;
            col_d[r*width_p +: width_p] = b_q[j*dim_p+r];
            col_v[r]                    = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    res_sel = '0;
    for (int k = 0; k < n_lp; k++) begin
      if (cnt_n == cnt_t'(k)) begin
        res_sel = arr_result_i[k*acc_width_p +: acc_width_p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      row_data_q  <= '0;
      row_valid_q <= '0;
      col_data_q  <= '0;
      col_valid_q <= '0;
      clear_q     <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else if (flush_i) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      row_data_q  <= '0;
      row_valid_q <= '0;
      col_data_q  <= '0;
      col_valid_q <= '0;
      clear_q     <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else if (en_i) begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      row_data_q  <= row_d;
      row_valid_q <= row_v;
      col_data_q  <= col_d;
      col_valid_q <= col_v;
      clear_q     <= (state_q == CLEAR);
      valid_q     <= (state_q == UNLOAD) && (state_n == UNLOAD);
      if ((state_q == UNLOAD) && (state_n == UNLOAD)) begin
        data_q <= res_sel;
      end else begin
        data_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < n_lp; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (beat && !flush_i) begin
      for (int i = 0; i < n_lp; i++) begin
        if (cnt_q == cnt_t'(i)) a_q[i] <= io.data_i;
        if (cnt_q == cnt_t'(n_lp + i)) b_q[i] <= io.data_i;
      end
    end
  end

`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;
  logic        perf_run_q;

  // The first beat counts as cycle 1; the final yumi cycle is included.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      perf_q     <= '0;
      perf_run_q <= 1'b0;
    end else if (flush_i) begin
      perf_q     <= '0;
      perf_run_q <= 1'b0;
    end else if (en_i) begin
      if (beat && (cnt_q == '0)) begin
        perf_q     <= 32'd1;
        perf_run_q <= 1'b1;
      end else if (perf_run_q) begin
        if (perf_q != '1) perf_q <= perf_q + 32'd1;
        if (yumi && (state_n == LOAD)) perf_run_q <= 1'b0;
      end
    end
  end

  assign perf_cycles_o = perf_q;
`endif

  assign io.ready_o  = ready;
  assign io.valid_o  = valid_q;
  assign io.data_o   = data_q;
  assign row_data_o  = row_data_q;
  assign row_valid_o = row_valid_q;
  assign col_data_o  = col_data_q;
  assign col_valid_o = col_valid_q;
  assign arr_clear_o = clear_q;
  assign busy_o      = (state_q != LOAD);

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: directed vectors, behavioural 2x2 PE grid, result scoreboard.
// Build with SYSTOLIC_SEQ_PERF_CNT_EN to also check perf_cycles_o.
module tb_systolic_sequencer;
  localparam int W  = 8;
  localparam int D  = 2;
  localparam int AW = 16;
  localparam int N  = D * D;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  systolic_sequencer_if #(.width_p(W), .acc_width_p(AW)) bus ();

  logic [D*W-1:0]  row_data, col_data;
  logic [D-1:0]    row_valid, col_valid;
  logic            arr_clear, busy;
  logic [N*AW-1:0] arr_result;
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  logic [31:0]     perf;
`endif

  systolic_sequencer #(.width_p(W), .dim_p(D), .acc_width_p(AW)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .en_i         (en),
    .flush_i      (flush),
    .io           (bus.slave),
    .row_data_o   (row_data),
    .row_valid_o  (row_valid),
    .col_data_o   (col_data),
    .col_valid_o  (col_valid),
    .arr_clear_o  (arr_clear),
    .arr_result_i (arr_result),
    .busy_o       (busy)
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    ,
    .perf_cycles_o(perf)
`endif
  );

  // Output-stationary PE grid: A flows east, B flows south.
  logic [W-1:0]  a_pipe [D][D];
  logic [W-1:0]  b_pipe [D][D];
  logic [W-1:0]  a_in   [D][D];
  logic [W-1:0]  b_in   [D][D];
  logic [AW-1:0] acc    [D][D];

  always_comb begin
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) begin
        a_in[r][c] = '0;
        b_in[r][c] = '0;
      end
    end
    for (int r = 0; r < D; r++) begin
      a_in[r][0] = row_data[r*W +: W];
      for (int c = 1; c < D; c++) a_in[r][c] = a_pipe[r][c-1];
    end
    for (int c = 0; c < D; c++) begin
      b_in[0][c] = col_data[c*W +: W];
      for (int r = 1; r < D; r++) b_in[r][c] = b_pipe[r-1][c];
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < D; r++) begin
        for (int c = 0; c < D; c++) begin
          a_pipe[r][c] <= '0;
          b_pipe[r][c] <= '0;
          acc[r][c]    <= '0;
        end
      end
    end else if (en) begin
      for (int r = 0; r < D; r++) begin
        for (int c = 0; c < D; c++) begin
          a_pipe[r][c] <= a_in[r][c];
          b_pipe[r][c] <= b_in[r][c];
          if (arr_clear) acc[r][c] <= '0;
          else acc[r][c] <= acc[r][c] + AW'(a_in[r][c]) * AW'(b_in[r][c]);
        end
      end
    end
  end

  always_comb begin
    arr_result = '0;
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) begin
        arr_result[(r*D+c)*AW +: AW] = acc[r][c];
      end
    end
  end

  logic [AW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int popped = 0;

  always @(negedge clk) begin
    if (bus.valid_o && en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got %0d", bus.data_o);
      end else begin
        if (bus.data_o !== exp_q[0]) begin
          errors++;
          $display("FAIL result got %0d exp %0d", bus.data_o, exp_q[0]);
        end
        if (bus.yumi_i) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input int r0, input int r1, input int r2, input int r3);
    exp_q.push_back(AW'(r0));
    exp_q.push_back(AW'(r1));
    exp_q.push_back(AW'(r2));
    exp_q.push_back(AW'(r3));
  endtask

  // Beat i of ops is ops[i*W +: W]: A row-major, then B row-major.
  task automatic load_ops(input logic [2*N*W-1:0] ops, input bit gap);
    for (int i = 0; i < 2 * N; i++) begin
      int tmo;
      tmo = 0;
      bus.valid_i = 1'b1;
      bus.data_i  = ops[i*W +: W];
      while (!bus.ready_o && tmo < 50) begin
        tick();
        tmo++;
      end
      chk("load_ready", 64'(bus.ready_o), 64'd1);
      tick();
      if (gap) begin
        bus.valid_i = 1'b0;
        tick();
      end
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_pops(input int target);
    int tmo;
    tmo = 0;
    while (popped < target && tmo < 300) begin
      tick();
      tmo++;
    end
    chk("pop_count", 64'(popped), 64'(target));
  endtask

  localparam logic [63:0] OPS_BASIC = 64'h04030201_04030201;
  localparam logic [63:0] OPS_TWO   = 64'h08070605_04030201;
  localparam logic [63:0] OPS_DIAG  = 64'h06050403_1400000A;

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int base;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.yumi_i  = 1'b1;
    repeat (3) tick();

    chk("rst_row_valid", 64'(row_valid), 64'd0);
    chk("rst_col_valid", 64'(col_valid), 64'd0);
    chk("rst_row_data", 64'(row_data), 64'd0);
    chk("rst_col_data", 64'(col_data), 64'd0);
    chk("rst_clear", 64'(arr_clear), 64'd0);
    chk("rst_valid_o", 64'(bus.valid_o), 64'd0);
    chk("rst_data_o", 64'(bus.data_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    chk("rst_perf", 64'(perf), 64'd0);
`endif
    reset_n = 1'b1;
    tick();

    // Basic multiply with skew and latency checks.
    push4(7, 10, 15, 22);
    load_ops(OPS_BASIC, 1'b0);
    tick();
    chk("clear_pulse", 64'(arr_clear), 64'd1);
    chk("busy_clear", 64'(busy), 64'd1);
    tick();
    chk("t0_row_v", 64'(row_valid), 64'h1);
    chk("t0_row_d", 64'(row_data), 64'h0001);
    chk("t0_col_v", 64'(col_valid), 64'h1);
    chk("t0_col_d", 64'(col_data), 64'h0001);
    chk("t0_clear", 64'(arr_clear), 64'd0);
    tick();
    chk("t1_row_v", 64'(row_valid), 64'h3);
    chk("t1_row_d", 64'(row_data), 64'h0302);
    chk("t1_col_v", 64'(col_valid), 64'h3);
    chk("t1_col_d", 64'(col_data), 64'h0203);
    tick();
    chk("t2_row_v", 64'(row_valid), 64'h2);
    chk("t2_row_d", 64'(row_data), 64'h0400);
    chk("t2_col_v", 64'(col_valid), 64'h2);
    chk("t2_col_d", 64'(col_data), 64'h0400);
    tick();
    chk("drain_row_v", 64'(row_valid), 64'h0);
    chk("drain_col_v", 64'(col_valid), 64'h0);
    chk("drain_row_d", 64'(row_data), 64'h0);
    tick();
    chk("lat6_valid_o", 64'(bus.valid_o), 64'd0);
    tick();
    chk("lat7_valid_o", 64'(bus.valid_o), 64'd1);
    wait_pops(4);
    chk("basic_ready_again", 64'(bus.ready_o), 64'd1);
    chk("basic_busy_low", 64'(busy), 64'd0);
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    chk("perf_basic", 64'(perf), 64'd19);
`endif

    // Backpressure at k=1.
    base = popped;
    push4(7, 10, 15, 22);
    load_ops(OPS_BASIC, 1'b0);
    wait_pops(base + 1);
    bus.yumi_i = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_valid_o", 64'(bus.valid_o), 64'd1);
      chk("stall_data_o", 64'(bus.data_o), 64'd10);
    end
    bus.yumi_i = 1'b1;
    wait_pops(base + 4);

    // Gapped operand stream.
    base = popped;
    push4(19, 22, 43, 50);
    load_ops(OPS_TWO, 1'b1);
    wait_pops(base + 4);

    // Flush at FEED t=1, then a fresh load.
    load_ops(OPS_BASIC, 1'b0);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_row_v", 64'(row_valid), 64'h0);
    chk("flush_col_v", 64'(col_valid), 64'h0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_ready", 64'(bus.ready_o), 64'd1);
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    chk("flush_perf", 64'(perf), 64'd0);
`endif
    base = popped;
    push4(30, 40, 100, 120);
    load_ops(OPS_DIAG, 1'b0);
    wait_pops(base + 4);

    // Enable low for 3 cycles during FEED.
    base = popped;
    push4(7, 10, 15, 22);
    load_ops(OPS_BASIC, 1'b0);
    tick();
    tick();
    en = 1'b0;
    repeat (3) begin
      tick();
      chk("frz_row_v", 64'(row_valid), 64'h1);
      chk("frz_row_d", 64'(row_data), 64'h0001);
      chk("frz_col_v", 64'(col_valid), 64'h1);
      chk("frz_ready", 64'(bus.ready_o), 64'd0);
    end
    en = 1'b1;
    wait_pops(base + 4);

    // Asynchronous reset mid-UNLOAD.
    base = popped;
    push4(7, 10, 15, 22);
    load_ops(OPS_BASIC, 1'b0);
    wait_pops(base + 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_valid_o", 64'(bus.valid_o), 64'd0);
    chk("arst_data_o", 64'(bus.data_o), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(bus.ready_o), 64'd1);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    base = popped;
    push4(19, 22, 43, 50);
    load_ops(OPS_TWO, 1'b0);
    wait_pops(base + 4);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
